// File: rtl/csrm_hpm.sv
// csrm_hpm: machine-mode hardware performance counter bank (mhpmcounter3..,
// mhpmevent3..) with per-privilege inhibits, per-counter overflow flags and a
// local-counter-overflow interrupt request.
module csrm_hpm #(
   parameter int XLEN         = 64,
   parameter int NUM_COUNTERS = 8,
   parameter int NUM_EVENTS   = 16,
   parameter int EVT_BITS     = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    StallW,
   input  logic                    CSRMWriteM,
   input  logic [11:0]             CSRAdrM,
   input  logic [XLEN-1:0]         CSRWriteValM,
   input  logic [1:0]              PrivilegeModeM,
   input  logic [31:0]             MCOUNTINHIBIT_REGW,
   input  logic [NUM_EVENTS-1:0]   EventsM,
   output logic [XLEN-1:0]         CSRHPMReadValM,
   output logic                    IllegalCSRHPMAccessM,
   output logic [NUM_COUNTERS-1:0] HPM_OF_REGW,
   output logic                    LCOFIRequestM
);

   localparam bit IS32 = (XLEN == 32);

   // Keep only codes that name a real event input; everything else means "no event".
   function automatic logic [EVT_BITS-1:0] legal_sel(input logic [EVT_BITS-1:0] code);
      logic [EVT_BITS-1:0] r;
      r = {EVT_BITS{1'b0}};
      if ((code != {EVT_BITS{1'b0}}) && (code <= EVT_BITS'(NUM_EVENTS))) r = code;
      else r = {EVT_BITS{1'b0}};
      return r;
   endfunction

   // Code k (1..NUM_EVENTS) picks EventsM[k-1]; code 0 never fires.
   function automatic logic evt_fire(input logic [EVT_BITS-1:0] sel, input logic [NUM_EVENTS-1:0] ev);
      logic r;
      r = 1'b0;
      for (int k = 1; k <= NUM_EVENTS; k++) r = r | ((sel == EVT_BITS'(k)) & ev[k-1]);
      return r;
   endfunction

   // Architectural state
   logic [63:0]          cnt_q [NUM_COUNTERS];
   logic [63:0]          cnt_d [NUM_COUNTERS];
   logic [EVT_BITS-1:0]  sel_q [NUM_COUNTERS];
   logic [EVT_BITS-1:0]  sel_d [NUM_COUNTERS];
   logic [NUM_COUNTERS-1:0] of_q, of_d, minh_q, minh_d, sinh_q, sinh_d, uinh_q, uinh_d;
   logic                 lcofi_q, lcofi_d;

   // Address decode
   logic [4:0]  idx_s;
   logic        in_cnt_s, in_cnth_s, in_evt_s, in_evth_s, legal_s, wr_en_s;
   logic [63:0] wval64_s;
   logic [3:0]  flag_src_s;
   logic [63:0] rd64_s;

   assign idx_s      = CSRAdrM[4:0];
   assign in_cnt_s   = (CSRAdrM[11:5] == 7'h58);   // 0xB00..0xB1F
   assign in_cnth_s  = (CSRAdrM[11:5] == 7'h5C);   // 0xB80..0xB9F
   assign in_evt_s   = (CSRAdrM[11:5] == 7'h19);   // 0x320..0x33F
   assign in_evth_s  = (CSRAdrM[11:5] == 7'h39);   // 0x720..0x73F
   // Indices 0..2 in these windows belong to mcycle/minstret/mcountinhibit, not here.
   assign legal_s    = (idx_s >= 5'd3) &&
                       (in_cnt_s || in_evt_s || (IS32 && (in_cnth_s || in_evth_s)));
   assign wr_en_s    = CSRMWriteM & ~StallW;
   assign wval64_s   = 64'(CSRWriteValM);
   // OF/MINH/SINH/UINH sit in bits 63:60 of the 64-bit view, i.e. bits 31:28 of mhpmeventh.
   assign flag_src_s = IS32 ? wval64_s[31:28] : wval64_s[63:60];

   // Per-counter next state: CSR writes, gated increments, overflow flagging.
   always_comb begin
      lcofi_d = 1'b0;
      of_d    = of_q;
      minh_d  = minh_q;
      sinh_d  = sinh_q;
      uinh_d  = uinh_q;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         logic hit, cnt_lo_wr, cnt_hi_wr, evt_lo_wr, flags_wr, priv_inh, inc, wrap;
         hit       = legal_s && wr_en_s && (idx_s == 5'(i + 3));
         cnt_lo_wr = hit && in_cnt_s;
         cnt_hi_wr = hit && in_cnth_s;
         evt_lo_wr = hit && in_evt_s;
         flags_wr  = IS32 ? (hit && in_evth_s) : evt_lo_wr;
         case (PrivilegeModeM)
            2'b11:   priv_inh = minh_q[i];
            2'b01:   priv_inh = sinh_q[i];
            2'b00:   priv_inh = uinh_q[i];
            default: priv_inh = 1'b0;
         endcase
         inc  = evt_fire(sel_q[i], EventsM) & ~MCOUNTINHIBIT_REGW[i + 3] & ~priv_inh &
                ~StallW & ~cnt_lo_wr & ~cnt_hi_wr;
         wrap = inc & (&cnt_q[i]);

         if (cnt_lo_wr)      cnt_d[i] = IS32 ? {cnt_q[i][63:32], wval64_s[31:0]} : wval64_s;
         else if (cnt_hi_wr) cnt_d[i] = {wval64_s[31:0], cnt_q[i][31:0]};
         else if (inc)       cnt_d[i] = cnt_q[i] + 64'd1;
         else                cnt_d[i] = cnt_q[i];

         if (evt_lo_wr) sel_d[i] = legal_sel(wval64_s[EVT_BITS-1:0]);
         else           sel_d[i] = sel_q[i];

         // A flag write by software beats a same-cycle hardware overflow set.
         if (flags_wr) begin
            of_d[i]   = flag_src_s[3];
            minh_d[i] = flag_src_s[2];
            sinh_d[i] = flag_src_s[1];
            uinh_d[i] = flag_src_s[0];
         end else if (wrap) begin
            of_d[i] = 1'b1;
         end else begin
            of_d[i] = of_q[i];
         end
         lcofi_d = lcofi_d | (wrap & ~of_q[i] & ~flags_wr);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt_q[i] <= 64'd0;
            sel_q[i] <= {EVT_BITS{1'b0}};
         end
         of_q    <= {NUM_COUNTERS{1'b0}};
         minh_q  <= {NUM_COUNTERS{1'b0}};
         sinh_q  <= {NUM_COUNTERS{1'b0}};
         uinh_q  <= {NUM_COUNTERS{1'b0}};
         lcofi_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt_q[i] <= cnt_d[i];
            sel_q[i] <= sel_d[i];
         end
         of_q    <= of_d;
         minh_q  <= minh_d;
         sinh_q  <= sinh_d;
         uinh_q  <= uinh_d;
         lcofi_q <= lcofi_d;
      end
   end

   // Combinational read mux; unimplemented legal indices fall through as zero.
   always_comb begin
      rd64_s = 64'd0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         logic [63:0] ev64;
         ev64 = {of_q[i], minh_q[i], sinh_q[i], uinh_q[i], {(60-EVT_BITS){1'b0}}, sel_q[i]};
         if (legal_s && (idx_s == 5'(i + 3))) begin
            if (in_cnt_s)       rd64_s = cnt_q[i];
            else if (in_cnth_s) rd64_s = {32'd0, cnt_q[i][63:32]};
            else if (in_evt_s)  rd64_s = ev64;
            else                rd64_s = {32'd0, ev64[63:32]};
         end else begin
            rd64_s = rd64_s;
         end
      end
   end

   assign CSRHPMReadValM       = rd64_s[XLEN-1:0];
   assign IllegalCSRHPMAccessM = ~legal_s;
   assign HPM_OF_REGW          = of_q;
   assign LCOFIRequestM        = lcofi_q;

endmodule
